// File: rtl/cgra_context_loader.sv
// ---------------------------------------------------------------------------
// cgra_context_loader
//
// Purpose:
//   This is the transmit side of the PE configuration interface.
//   - It takes context words from a valid/ready source.
//   - It broadcasts them on a shared data bus to the per-PE context caches.
//     A one-hot write strobe picks the target PE, and an entry address picks
//     the cache slot.
//   - When every PE has received its contexts, it pulses start so all PE
//     context pointers restart at 0, then pulses done.
//
// Ports:
//   CLK          in   1          clock, rising edge
//   RST_N        in   1          asynchronous active-low reset
//   cfg_go       in   1          one-cycle request to start a load
//   cfg_num_ctx  in   CTX_W+1    contexts per PE (legal 1..DEPTH), sampled on cfg_go
//   src_valid    in   1          source word valid
//   src_data     in   WIDTH+1    source context word
//   src_ready    out  1          loader accepts src_data this cycle
//   pe_data      out  WIDTH+1    context word broadcast to all PEs
//   pe_wr_en     out  NUM_PE     one-hot cache write strobe
//   pe_wr_addr   out  CTX_W      cache entry being written
//   start        out  1          one-cycle pulse, PEs restart context pointer
//   busy         out  1          high from accepted cfg_go until done
//   done         out  1          one-cycle pulse, load complete
//   err          out  1          one-cycle pulse, illegal cfg_num_ctx
// ---------------------------------------------------------------------------
module cgra_context_loader #(
  parameter int WIDTH  = 120,
  parameter int NUM_PE = 16,
  parameter int DEPTH  = 16,
  parameter int PE_W   = 4,
  parameter int CTX_W  = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cfg_go,
  input  logic [CTX_W:0]    cfg_num_ctx,
  input  logic              src_valid,
  input  logic [WIDTH:0]    src_data,
  output logic              src_ready,
  output logic [WIDTH:0]    pe_data,
  output logic [NUM_PE-1:0] pe_wr_en,
  output logic [CTX_W-1:0]  pe_wr_addr,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q,      state_d;
  logic [CTX_W:0]    num_ctx_q,    num_ctx_d;
  logic [PE_W-1:0]   pe_idx_q,     pe_idx_d;
  logic [CTX_W-1:0]  ctx_idx_q,    ctx_idx_d;
  logic [WIDTH:0]    pe_data_q,    pe_data_d;
  logic [NUM_PE-1:0] pe_wr_en_q,   pe_wr_en_d;
  logic [CTX_W-1:0]  pe_wr_addr_q, pe_wr_addr_d;
  logic              start_q,      start_d;
  logic              done_q,       done_d;
  logic              err_q,        err_d;
  logic              busy_q,       busy_d;

  logic beat;
  logic cfg_legal;
  logic last_ctx;
  logic last_pe;

  // The loader never stalls while loading.
  // A gap in the source only delays the next beat.
  assign src_ready = (state_q == S_LOAD);
  assign beat      = src_valid & src_ready;

  assign cfg_legal = (cfg_num_ctx != '0) &&
                     (cfg_num_ctx <= (CTX_W+1)'(DEPTH));

  // num_ctx is at least 1 whenever we are in LOAD, so n-1 never underflows.
  assign last_ctx  = ({1'b0, ctx_idx_q} == (num_ctx_q - (CTX_W+1)'(1)));
  assign last_pe   = (pe_idx_q == PE_W'(NUM_PE - 1));

  always_comb begin
    state_d      = state_q;
    num_ctx_d    = num_ctx_q;
    pe_idx_d     = pe_idx_q;
    ctx_idx_d    = ctx_idx_q;
    pe_data_d    = pe_data_q;
    pe_wr_addr_d = pe_wr_addr_q;
    pe_wr_en_d   = '0;
    start_d      = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_go) begin
          if (cfg_legal) begin
            num_ctx_d = cfg_num_ctx;
            pe_idx_d  = '0;
            ctx_idx_d = '0;
            state_d   = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (beat) begin
          pe_data_d    = src_data;
          pe_wr_addr_d = ctx_idx_q;
          pe_wr_en_d   = NUM_PE'(1) << pe_idx_q;
          // The stream is PE-major.
          // The context index wraps into the next PE.
          if (last_ctx) begin
            ctx_idx_d = '0;
            if (last_pe) begin
              state_d = S_START;
            end else begin
              pe_idx_d = pe_idx_q + PE_W'(1);
            end
          end else begin
            ctx_idx_d = ctx_idx_q + CTX_W'(1);
          end
        end
      end

      S_START: begin
        start_d = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // All outputs are registered.
  // An asynchronous reset clears them immediately and abandons any load
  // in progress.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      num_ctx_q    <= '0;
      pe_idx_q     <= '0;
      ctx_idx_q    <= '0;
      pe_data_q    <= '0;
      pe_wr_en_q   <= '0;
      pe_wr_addr_q <= '0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_ctx_q    <= num_ctx_d;
      pe_idx_q     <= pe_idx_d;
      ctx_idx_q    <= ctx_idx_d;
      pe_data_q    <= pe_data_d;
      pe_wr_en_q   <= pe_wr_en_d;
      pe_wr_addr_q <= pe_wr_addr_d;
      start_q      <= start_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign pe_data    = pe_data_q;
  assign pe_wr_en   = pe_wr_en_q;
  assign pe_wr_addr = pe_wr_addr_q;
  assign start      = start_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cgra_context_loader.sv
// ---------------------------------------------------------------------------
// tb_cgra_context_loader
//
// Directed testbench for cgra_context_loader.
// - A negedge monitor logs every strobe, start, done and err event, together
//   with the busy and src_ready levels of each cycle.
// - Each test task drives a load and checks the log against expectations
//   that the task computes by hand.
// ---------------------------------------------------------------------------
module tb_cgra_context_loader;

   localparam int WIDTH  = 120;
   localparam int NUM_PE = 16;
   localparam int DEPTH  = 16;
   localparam int PE_W   = 4;
   localparam int CTX_W  = 4;

   logic              CLK = 1'b0;
   logic              RST_N = 1'b0;
   logic              cfg_go = 1'b0;
   logic [CTX_W:0]    cfg_num_ctx = '0;
   logic              src_valid = 1'b0;
   logic [WIDTH:0]    src_data = '0;
   logic              src_ready;
   logic [WIDTH:0]    pe_data;
   logic [NUM_PE-1:0] pe_wr_en;
   logic [CTX_W-1:0]  pe_wr_addr;
   logic              start;
   logic              busy;
   logic              done;
   logic              err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   cgra_context_loader #(
      .WIDTH(WIDTH), .NUM_PE(NUM_PE), .DEPTH(DEPTH), .PE_W(PE_W), .CTX_W(CTX_W)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .cfg_go(cfg_go), .cfg_num_ctx(cfg_num_ctx),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .pe_data(pe_data), .pe_wr_en(pe_wr_en), .pe_wr_addr(pe_wr_addr),
      .start(start), .busy(busy), .done(done), .err(err)
   );

   // 10-time-unit clock with a free-running cycle counter.
   // The counter steps on each rising edge.
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int                c;
      logic [NUM_PE-1:0] en;
      logic [CTX_W-1:0]  addr;
      logic [WIDTH:0]    data;
   } strobe_t;

   strobe_t strobes[$];
   int      startCyc[$];
   int      doneCyc[$];
   int      errCyc[$];
   int      overlap = 0;
   logic    busyLog[0:4095];
   logic    readyLog[0:4095];

   // Sample outputs on the falling edge, well away from the active edge.
   always @(negedge CLK) begin
      strobe_t s;
      if (pe_wr_en !== '0) begin
         s.c = cyc;
         s.en = pe_wr_en;
         s.addr = pe_wr_addr;
         s.data = pe_data;
         strobes.push_back(s);
      end
      if (start === 1'b1) begin
         startCyc.push_back(cyc);
         if (pe_wr_en !== '0 || done === 1'b1 || err === 1'b1) overlap++;
      end
      if (done === 1'b1) doneCyc.push_back(cyc);
      if (err === 1'b1) errCyc.push_back(cyc);
      if (cyc < 4096) begin
         busyLog[cyc] = busy;
         readyLog[cyc] = src_ready;
      end
   end

   // Distinct, recognisable word for each beat.
   // Every field of the word is populated.
   function automatic logic [WIDTH:0] mkWord(input int b, input int salt);
      logic [31:0] x;
      x = b;
      return {25'(x ^ salt), 32'(x * 32'h9E3779B1), 32'(~x + salt), 32'(x ^ 32'h5A5A0000)};
   endfunction

   task automatic clearLogs();
      strobes.delete();
      startCyc.delete();
      doneCyc.delete();
      errCyc.delete();
      overlap = 0;
   endtask

   // Issue cfg_go, then drive stopAfterBeats words.
   // - With toggle set, valid goes 1,0,1,0...
   // - Optionally re-pulse cfg_go on beat goAgainBeat.
   // goCyc is the cycle in which cfg_go was high.
   task automatic applyStimulus(input int n, input bit toggle, input int goAgainBeat,
                                input int stopAfterBeats, input int salt, output int goCyc);
      int beatIdx;
      int off;
      bit v;
      @(posedge CLK); #1;
      cfg_go = 1'b1;
      cfg_num_ctx = (CTX_W+1)'(n);
      src_valid = 1'b0;
      goCyc = cyc;
      @(posedge CLK); #1;
      cfg_go = 1'b0;
      beatIdx = 0;
      off = 1;
      while (beatIdx < stopAfterBeats) begin
         v = toggle ? ((off - 1) % 2 == 0) : 1'b1;
         src_valid = v;
         src_data = mkWord(beatIdx, salt);
         cfg_go = (goAgainBeat >= 0 && beatIdx == goAgainBeat && v);
         cfg_num_ctx = cfg_go ? (CTX_W+1)'(2) : (CTX_W+1)'(n);
         @(posedge CLK); #1;
         if (v) beatIdx++;
         off++;
      end
      cfg_go = 1'b0;
      src_valid = 1'b0;
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      #12;
      checks++;
      if (pe_wr_en !== '0 || pe_data !== '0 || pe_wr_addr !== '0 || start !== 1'b0 ||
          done !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || src_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: en=%h data=%h addr=%h start=%b done=%b busy=%b err=%b ready=%b, all required 0",
                  pe_wr_en, pe_data, pe_wr_addr, start, done, busy, err, src_ready);
      end
      @(posedge CLK); #1;
      RST_N = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (busy !== 1'b0 || src_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL idle_after_reset: busy=%b ready=%b required 0/0", busy, src_ready);
      end
   endtask

   // n=4 with a continuous source.
   // After the load, valid stays high for a while and must be ignored.
   task automatic test_continuous();
      int g;
      int n;
      logic [NUM_PE-1:0] expEn;
      n = 4;
      clearLogs();
      applyStimulus(n, 1'b0, -1, NUM_PE * n, 32'h11, g);
      src_valid = 1'b1;
      src_data = '1;
      repeat (3) @(posedge CLK);
      #1;
      src_valid = 1'b0;
      repeat (6) @(posedge CLK);
      #1;

      checks++;
      if (strobes.size() != NUM_PE * n) begin
         failures++;
         $display("[TB] FAIL cont_strobe_count: got %0d required %0d", strobes.size(), NUM_PE * n);
      end
      for (int k = 0; k < strobes.size() && k < NUM_PE * n; k++) begin
         expEn = '0;
         expEn[k / n] = 1'b1;
         checks++;
         if (strobes[k].c != g + 2 + k || strobes[k].en !== expEn ||
             strobes[k].addr !== CTX_W'(k % n) || strobes[k].data !== mkWord(k, 32'h11)) begin
            failures++;
            $display("[TB] FAIL cont_strobe_%0d: cyc=%0d en=%h addr=%0d data=%h required cyc=%0d en=%h addr=%0d data=%h",
                     k, strobes[k].c - g, strobes[k].en, strobes[k].addr, strobes[k].data,
                     2 + k, expEn, k % n, mkWord(k, 32'h11));
         end
      end
      checks++;
      if (startCyc.size() != 1 || (startCyc.size() > 0 && startCyc[0] != g + 66)) begin
         failures++;
         $display("[TB] FAIL cont_start: count=%0d first=%0d required count=1 at 66",
                  startCyc.size(), startCyc.size() > 0 ? startCyc[0] - g : -1);
      end
      checks++;
      if (doneCyc.size() != 1 || (doneCyc.size() > 0 && doneCyc[0] != g + 67)) begin
         failures++;
         $display("[TB] FAIL cont_done: count=%0d first=%0d required count=1 at 67",
                  doneCyc.size(), doneCyc.size() > 0 ? doneCyc[0] - g : -1);
      end
      checks++;
      if (overlap != 0 || errCyc.size() != 0) begin
         failures++;
         $display("[TB] FAIL cont_exclusive: overlap=%0d errs=%0d required 0/0", overlap, errCyc.size());
      end
      checks++;
      if (busyLog[g] !== 1'b0 || busyLog[g+1] !== 1'b1 || busyLog[g+66] !== 1'b1 || busyLog[g+67] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL cont_busy: @0=%b @1=%b @66=%b @67=%b required 0,1,1,0",
                  busyLog[g], busyLog[g+1], busyLog[g+66], busyLog[g+67]);
      end
      checks++;
      if (readyLog[g] !== 1'b0 || readyLog[g+1] !== 1'b1 || readyLog[g+64] !== 1'b1 || readyLog[g+65] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL cont_ready: @0=%b @1=%b @64=%b @65=%b required 0,1,1,0",
                  readyLog[g], readyLog[g+1], readyLog[g+64], readyLog[g+65]);
      end
   endtask

   // n=1 with the source toggling valid every cycle.
   // Strobes must land only on the cycles that follow a beat.
   task automatic test_gaps();
      int g;
      logic [NUM_PE-1:0] expEn;
      clearLogs();
      applyStimulus(1, 1'b1, -1, NUM_PE, 32'h2E, g);
      repeat (6) @(posedge CLK);
      #1;
      checks++;
      if (strobes.size() != NUM_PE) begin
         failures++;
         $display("[TB] FAIL gap_strobe_count: got %0d required %0d", strobes.size(), NUM_PE);
      end
      for (int k = 0; k < strobes.size() && k < NUM_PE; k++) begin
         expEn = '0;
         expEn[k] = 1'b1;
         checks++;
         if (strobes[k].c != g + 2 + 2 * k || strobes[k].en !== expEn ||
             strobes[k].addr !== '0 || strobes[k].data !== mkWord(k, 32'h2E)) begin
            failures++;
            $display("[TB] FAIL gap_strobe_%0d: cyc=%0d en=%h addr=%0d data=%h required cyc=%0d en=%h addr=0 data=%h",
                     k, strobes[k].c - g, strobes[k].en, strobes[k].addr, strobes[k].data,
                     2 + 2 * k, expEn, mkWord(k, 32'h2E));
         end
      end
      checks++;
      if (startCyc.size() != 1 || doneCyc.size() != 1 ||
          (startCyc.size() > 0 && startCyc[0] != g + 33) || (doneCyc.size() > 0 && doneCyc[0] != g + 34)) begin
         failures++;
         $display("[TB] FAIL gap_start_done: starts=%0d dones=%0d start@%0d done@%0d required 1/1 at 33/34",
                  startCyc.size(), doneCyc.size(),
                  startCyc.size() > 0 ? startCyc[0] - g : -1, doneCyc.size() > 0 ? doneCyc[0] - g : -1);
      end
   endtask

   // cfg_num_ctx of 0 and of DEPTH+1 must each pulse err for one cycle.
   // Neither may start a load.
   task automatic test_illegal();
      int g;
      int vals[2];
      vals[0] = 0;
      vals[1] = DEPTH + 1;
      for (int i = 0; i < 2; i++) begin
         clearLogs();
         @(posedge CLK); #1;
         cfg_go = 1'b1;
         cfg_num_ctx = (CTX_W+1)'(vals[i]);
         src_valid = 1'b1;
         g = cyc;
         @(posedge CLK); #1;
         cfg_go = 1'b0;
         repeat (4) @(posedge CLK);
         #1;
         src_valid = 1'b0;
         checks++;
         if (errCyc.size() != 1 || (errCyc.size() > 0 && errCyc[0] != g + 1)) begin
            failures++;
            $display("[TB] FAIL illegal_err_%0d: count=%0d first=%0d required count=1 at 1",
                     vals[i], errCyc.size(), errCyc.size() > 0 ? errCyc[0] - g : -1);
         end
         checks++;
         if (busyLog[g+1] !== 1'b0 || busyLog[g+2] !== 1'b0 || strobes.size() != 0 || startCyc.size() != 0) begin
            failures++;
            $display("[TB] FAIL illegal_quiet_%0d: busy=%b%b strobes=%0d starts=%0d required 0,0,0,0",
                     vals[i], busyLog[g+1], busyLog[g+2], strobes.size(), startCyc.size());
         end
      end
   endtask

   // Re-pulse cfg_go mid-load.
   // The load must be unaffected and must not raise err.
   task automatic test_back_to_back();
      int g;
      int n;
      logic [NUM_PE-1:0] expEn;
      n = 4;
      clearLogs();
      applyStimulus(n, 1'b0, 10, NUM_PE * n, 32'h47, g);
      repeat (6) @(posedge CLK);
      #1;
      checks++;
      if (strobes.size() != NUM_PE * n) begin
         failures++;
         $display("[TB] FAIL b2b_strobe_count: got %0d required %0d", strobes.size(), NUM_PE * n);
      end
      for (int k = 0; k < strobes.size() && k < NUM_PE * n; k++) begin
         expEn = '0;
         expEn[k / n] = 1'b1;
         checks++;
         if (strobes[k].en !== expEn || strobes[k].addr !== CTX_W'(k % n) ||
             strobes[k].data !== mkWord(k, 32'h47)) begin
            failures++;
            $display("[TB] FAIL b2b_strobe_%0d: en=%h addr=%0d required en=%h addr=%0d",
                     k, strobes[k].en, strobes[k].addr, expEn, k % n);
         end
      end
      checks++;
      if (doneCyc.size() != 1 || errCyc.size() != 0 || (doneCyc.size() > 0 && doneCyc[0] != g + 67)) begin
         failures++;
         $display("[TB] FAIL b2b_done: dones=%0d errs=%0d done@%0d required 1/0 at 67",
                  doneCyc.size(), errCyc.size(), doneCyc.size() > 0 ? doneCyc[0] - g : -1);
      end
   endtask

   // Reset during a load, then run a fresh full-depth load.
   task automatic test_mid_reset();
      int g;
      int n;
      logic [NUM_PE-1:0] expEn;
      clearLogs();
      applyStimulus(3, 1'b0, -1, 21, 32'h5C, g);
      // Beat 20 (PE 6, ctx 2) is on the bus in this cycle.
      checks++;
      if (pe_wr_en !== 16'h0040 || pe_wr_addr !== 4'd2) begin
         failures++;
         $display("[TB] FAIL pre_reset_strobe: en=%h addr=%0d required 0040/2", pe_wr_en, pe_wr_addr);
      end
      #2;
      RST_N = 1'b0;
      #1;
      checks++;
      if (pe_wr_en !== '0 || pe_data !== '0 || pe_wr_addr !== '0 || start !== 1'b0 ||
          done !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || src_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midreset_outputs: en=%h addr=%h start=%b done=%b busy=%b err=%b ready=%b required all 0",
                  pe_wr_en, pe_wr_addr, start, done, busy, err, src_ready);
      end
      clearLogs();
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      repeat (5) @(posedge CLK);
      #1;
      checks++;
      if (strobes.size() != 0 || startCyc.size() != 0 || doneCyc.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midreset_quiet: strobes=%0d starts=%0d dones=%0d busy=%b required 0,0,0,0",
                  strobes.size(), startCyc.size(), doneCyc.size(), busy);
      end

      n = DEPTH;
      clearLogs();
      applyStimulus(n, 1'b0, -1, NUM_PE * n, 32'h7A, g);
      repeat (6) @(posedge CLK);
      #1;
      checks++;
      if (strobes.size() != NUM_PE * n) begin
         failures++;
         $display("[TB] FAIL full_strobe_count: got %0d required %0d", strobes.size(), NUM_PE * n);
      end
      for (int k = 0; k < strobes.size() && k < NUM_PE * n; k++) begin
         expEn = '0;
         expEn[k / n] = 1'b1;
         checks++;
         if (strobes[k].c != g + 2 + k || strobes[k].en !== expEn ||
             strobes[k].addr !== CTX_W'(k % n) || strobes[k].data !== mkWord(k, 32'h7A)) begin
            failures++;
            $display("[TB] FAIL full_strobe_%0d: cyc=%0d en=%h addr=%0d required cyc=%0d en=%h addr=%0d",
                     k, strobes[k].c - g, strobes[k].en, strobes[k].addr, 2 + k, expEn, k % n);
         end
      end
      checks++;
      if (startCyc.size() != 1 || doneCyc.size() != 1 ||
          (startCyc.size() > 0 && startCyc[0] != g + 258) || (doneCyc.size() > 0 && doneCyc[0] != g + 259)) begin
         failures++;
         $display("[TB] FAIL full_start_done: starts=%0d dones=%0d start@%0d done@%0d required 1/1 at 258/259",
                  startCyc.size(), doneCyc.size(),
                  startCyc.size() > 0 ? startCyc[0] - g : -1, doneCyc.size() > 0 ? doneCyc[0] - g : -1);
      end
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_gaps();
      test_illegal();
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
